sub16_serial: RTL and testbench



---
 rtl/sub16_serial_pkg.sv | 20 ++
 rtl/sub16_serial_nibble.sv | 29 ++
 rtl/sub16_serial.sv | 127 ++++++++++++
 tb/tb_sub16_serial.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sub16_serial_pkg.sv
// Shared definitions for the nibble-serial 16-bit subtractor: state encoding,
// default widths and the index-width helper.
package sub16_serial_pkg;

    localparam int WIDTH_DEF   = 16;
    localparam int NIB_W_DEF   = 4;
    localparam int NIBBLES_DEF = WIDTH_DEF / NIB_W_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-nibble datapath still needs a 1-bit index register.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/sub16_serial_nibble.sv
// 4-bit borrow-lookahead subtractor slice: d = x - y - bin, purely combinational.
module borrow_lookahead_sub_4bit (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] b;

    // g: this bit borrows on its own; p: equal bits pass the incoming borrow on.
    assign g = ~x & y;
    assign p = ~(x ^ y);

    assign b[0] = bin;
    assign b[1] = g[0] | (p[0] & bin);
    assign b[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    assign b[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & bin);
    assign b[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bin);

    assign d    = x ^ y ^ b[3:0];
    assign bout = b[4];

endmodule

// File: rtl/sub16_serial.sv
// Multi-cycle subtractor z = x - y, one nibble per clock with a registered
// borrow, valid/ready on both sides and adder-compatible flags.
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for an operand pair
//   RUN   | one nibble per cycle, idx 0..NIBBLES-1
//   DONE  | out_valid=1, z and flags held until out_ready
module sub16_serial
    import sub16_serial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NIB_W = NIB_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             sign,
    output logic             zero,
    output logic             borrow,
    output logic             parity,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIB_W;
    localparam int IDX_W   = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic [WIDTH-1:0] z_nxt;
    logic [IDX_W-1:0] idx;
    logic             brw;
    logic             last;
    logic             accept;
    logic [NIB_W-1:0] nib_x;
    logic [NIB_W-1:0] nib_y;
    logic [NIB_W-1:0] nib_d;
    logic             nib_bout;

    assign last   = (idx == LAST_IDX);
    assign accept = in_valid & in_ready;
    assign nib_x  = xr[idx*NIB_W +: NIB_W];
    assign nib_y  = yr[idx*NIB_W +: NIB_W];

    borrow_lookahead_sub_4bit u_nib (
        .x    (nib_x),
        .y    (nib_y),
        .bin  (brw),
        .d    (nib_d),
        .bout (nib_bout)
    );

    // Result with the current nibble merged in; on the last nibble this is the final z.
    always_comb begin
        z_nxt = z;
        z_nxt[idx*NIB_W +: NIB_W] = nib_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr       <= '0;
            yr       <= '0;
            idx      <= '0;
            brw      <= 1'b0;
            z        <= '0;
            sign     <= 1'b0;
            zero     <= 1'b0;
            borrow   <= 1'b0;
            parity   <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            xr  <= x;
            yr  <= y;
            idx <= '0;
            brw <= 1'b0;
        end else if (state == RUN) begin
            z   <= z_nxt;
            brw <= nib_bout;
            idx <= last ? '0 : idx + 1'b1;
            if (last) begin
                sign     <= z_nxt[WIDTH-1];
                zero     <= ~|z_nxt;
                borrow   <= nib_bout;
                parity   <= ~^z_nxt;
                overflow <= (xr[WIDTH-1] & ~yr[WIDTH-1] & ~z_nxt[WIDTH-1])
                          | (~xr[WIDTH-1] & yr[WIDTH-1] & z_nxt[WIDTH-1]);
            end
        end
    end

endmodule

// File: tb/tb_sub16_serial.sv
// Randomized self-checking bench for sub16_serial against an arithmetic
// reference of x - y and its flags.
module tb_sub16_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] z;
    logic        sign;
    logic        zero;
    logic        borrow;
    logic        parity;
    logic        overflow;

    int nchecks = 0;
    int nerrors = 0;

    always #5 clk = ~clk;

    sub16_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .sign      (sign),
        .zero      (zero),
        .borrow    (borrow),
        .parity    (parity),
        .overflow  (overflow)
    );

    // {z, sign, zero, borrow, parity, overflow} from plain integer arithmetic.
    function automatic logic [20:0] model(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] d;
        int          sd;
        logic        ovf;
        logic        brw;
        logic        par;
        d   = a - b;
        brw = (a < b);
        sd  = int'($signed(a)) - int'($signed(b));
        ovf = (sd > 32767) || (sd < -32768);
        par = ($countones(d) % 2) == 0;
        return {d, d[15], (d == 16'h0000), brw, par, ovf};
    endfunction

    // One operation: accept, check latency, check result, hold in DONE for
    // 'hold' cycles while offering operands (na, nb), then release.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                          input logic [15:0] na, input logic [15:0] nb, input string tag);
        logic [20:0] exp;
        logic [20:0] got;
        int          e;
        exp = model(a, b);
        @(negedge clk);
        in_valid  = 1'b1;
        x         = a;
        y         = b;
        out_ready = 1'b0;
        nchecks++;
        if (in_ready !== 1'b1) begin
            nerrors++;
            $display("FAIL %s in_ready_before_accept got=%b want=1", tag, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        e = 0;
        while (out_valid !== 1'b1 && e < 20) begin
            in_valid = 1'(($urandom_range(0, 1)));
            x        = 16'($urandom);
            y        = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            e++;
        end
        in_valid = 1'b0;
        nchecks++;
        if (e !== 4) begin
            nerrors++;
            $display("FAIL %s latency got=%0d edges after accept want=4", tag, e);
        end
        got = {z, sign, zero, borrow, parity, overflow};
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s result x=%h y=%h got z=%h flags(s,z,b,p,o)=%b want z=%h flags=%b",
                     tag, a, b, got[20:5], got[4:0], exp[20:5], exp[4:0]);
        end
        nchecks++;
        if (in_ready !== 1'b0) begin
            nerrors++;
            $display("FAIL %s in_ready_in_done got=%b want=0", tag, in_ready);
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            x        = na;
            y        = nb;
            @(posedge clk);
            @(negedge clk);
            got = {z, sign, zero, borrow, parity, overflow};
            nchecks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || got !== exp) begin
                nerrors++;
                $display("FAIL %s hold_cycle_%0d got ov=%b ir=%b z=%h flags=%b want ov=1 ir=0 z=%h flags=%b",
                         tag, i, out_valid, in_ready, got[20:5], got[4:0], exp[20:5], exp[4:0]);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        nchecks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nerrors++;
            $display("FAIL %s release got ov=%b ir=%b want ov=0 ir=1", tag, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = 16'h0;
        y         = 16'h0;
        repeat (3) @(negedge clk);
        nchecks++;
        if ({in_ready, out_valid, z, sign, zero, borrow, parity, overflow} !== {1'b1, 1'b0, 21'h0}) begin
            nerrors++;
            $display("FAIL reset_state got ir=%b ov=%b z=%h flags=%b want ir=1 ov=0 z=0000 flags=00000",
                     in_ready, out_valid, z, {sign, zero, borrow, parity, overflow});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        nchecks++;
        if ({in_ready, out_valid, z} !== {1'b1, 1'b0, 16'h0}) begin
            nerrors++;
            $display("FAIL idle_after_reset got ir=%b ov=%b z=%h want ir=1 ov=0 z=0000",
                     in_ready, out_valid, z);
        end
    endtask

    task automatic test_directed();
        run_op(16'h8fff, 16'h8000, 0, 16'h0, 16'h0, "d_8fff_8000");
        run_op(16'h0002, 16'hfafe, 0, 16'h0, 16'h0, "d_0002_fafe");
        run_op(16'h8000, 16'h0001, 0, 16'h0, 16'h0, "d_8000_0001");
        run_op(16'h1234, 16'h1234, 0, 16'h0, 16'h0, "d_1234_1234");
        run_op(16'h0000, 16'h0001, 0, 16'h0, 16'h0, "d_0000_0001");
        run_op(16'h7fff, 16'hffff, 0, 16'h0, 16'h0, "d_7fff_ffff");
        run_op(16'hffff, 16'hffff, 0, 16'h0, 16'h0, "d_ffff_ffff");
    endtask

    task automatic test_backpressure();
        run_op(16'h4321, 16'h0f0f, 10, 16'hbeef, 16'h1337, "bp_hold");
        run_op(16'hbeef, 16'h1337, 0, 16'h0, 16'h0, "bp_next");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1;
        x        = 16'h1234;
        y        = 16'h0f0f;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        nchecks++;
        if ({in_ready, out_valid, z, sign, zero, borrow, parity, overflow} !== {1'b1, 1'b0, 21'h0}) begin
            nerrors++;
            $display("FAIL reset_mid got ir=%b ov=%b z=%h flags=%b want ir=1 ov=0 z=0000 flags=00000",
                     in_ready, out_valid, z, {sign, zero, borrow, parity, overflow});
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h8fff, 16'h8000, 0, 16'h0, 16'h0, "after_reset_mid");
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        for (int n = 0; n < 150; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 7))
                0: b = a;
                1: a = 16'h8000;
                2: b = 16'h8000;
                3: a = 16'h0000;
                default: ;
            endcase
            run_op(a, b, int'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
